// File: rtl/exec_unit_p.sv
// exec_unit_p: single-issue execute unit with operand forwarding, a
// one-cycle ALU path and a multi-cycle restoring unsigned divider.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   stall                    downstream stall; result registers hold
//   in_valid / in_ready      operation handshake (in_ready = !stall && !div_busy)
//   op                       000 add, 001 sub, 010 and, 011 or, 100 xor,
//                            101 sll, 110 srl, 111 unsigned div
//   rs_data, rt_data         register-file operands A and B
//   fwd_rs_en/sel, fwd_rt_en/sel, fwd_data
//                            forwarding override of A / B from NUM_FWD sources
//   wdata_in                 store data carried alongside the result
//   out_valid                result registers hold a new result
//   alu_out, rem_out         result or quotient, remainder
//   wdata_out                store data that belongs to the result
//   div_busy                 divider is iterating or waiting to issue
//   div_by_zero              current result is a divide with B = 0
module exec_unit_p #(
   parameter int WIDTH   = 16,
   parameter int NUM_FWD = 4,
   localparam int SEL_W  = $clog2(NUM_FWD)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               op,
   input  logic [WIDTH-1:0]         rs_data,
   input  logic [WIDTH-1:0]         rt_data,
   input  logic                     fwd_rs_en,
   input  logic                     fwd_rt_en,
   input  logic [SEL_W-1:0]         fwd_rs_sel,
   input  logic [SEL_W-1:0]         fwd_rt_sel,
   input  logic [NUM_FWD*WIDTH-1:0] fwd_data,
   input  logic [WIDTH-1:0]         wdata_in,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         alu_out,
   output logic [WIDTH-1:0]         rem_out,
   output logic [WIDTH-1:0]         wdata_out,
   output logic                     div_busy,
   output logic                     div_by_zero
);

   localparam int SH_W  = $clog2(WIDTH);
   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRL = 3'b110;
   localparam logic [2:0] OP_DIV = 3'b111;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   a, b, alu_res;
   logic               accept, is_div, div_start;
   logic [WIDTH-1:0]   quo_p1, rem_p1, dvs_p1, wdata_p1;

   // One restoring-division step: shift the next dividend bit into the
   // partial remainder, subtract the divisor, and keep the difference only
   // when it did not go negative. Returns {remainder, quotient}.
   function automatic logic [2*WIDTH-1:0] div_step(
      input logic [WIDTH-1:0] rem,
      input logic [WIDTH-1:0] quo,
      input logic [WIDTH-1:0] dvs
   );
      logic [WIDTH:0] shifted;
      logic [WIDTH:0] trial;
      shifted = {rem, quo[WIDTH-1]};
      trial   = shifted - {1'b0, dvs};
      if (trial[WIDTH])
         return {shifted[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
      else
         return {trial[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
   endfunction

   // Out-of-range select indices match no source and leave the register
   // operand in place.
   always_comb begin
      a = rs_data;
      b = rt_data;
      for (int k = 0; k < NUM_FWD; k++) begin
         if (fwd_rs_en && fwd_rs_sel == SEL_W'(k)) a = fwd_data[k*WIDTH +: WIDTH];
         if (fwd_rt_en && fwd_rt_sel == SEL_W'(k)) b = fwd_data[k*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD:  alu_res = a + b;
         OP_SUB:  alu_res = a - b;
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_SLL:  alu_res = a << b[SH_W-1:0];
         OP_SRL:  alu_res = a >> b[SH_W-1:0];
         default: alu_res = '0;
      endcase
   end

   assign div_busy  = !rst && (state != IDLE);
   assign in_ready  = !rst && !stall && !div_busy;
   assign accept    = in_valid && in_ready;
   assign is_div    = (op == OP_DIV);
   assign div_start = accept && is_div && (b != '0);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (div_start) state_nxt = RUN;
         RUN:     if (cnt == CNT_W'(WIDTH-1)) state_nxt = DONE;
         DONE:    if (!stall) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Iteration counter runs 0..WIDTH-1 while in RUN; stall does not pause it.
   always_ff @(posedge clk) begin
      if (rst)               cnt <= '0;
      else if (state == RUN) cnt <= cnt + 1'b1;
      else                   cnt <= '0;
   end

   // ---- stage p1: divider operand latch and iteration ----
   // Left unreset: an aborted division is never issued, because the FSM
   // returns to IDLE and only DONE copies these into the outputs.
   always_ff @(posedge clk) begin
      if (div_start) begin
         quo_p1   <= a;
         rem_p1   <= '0;
         dvs_p1   <= b;
         wdata_p1 <= wdata_in;
      end else if (state == RUN) begin
         {rem_p1, quo_p1} <= div_step(rem_p1, quo_p1, dvs_p1);
      end
   end

   // ---- result registers ----
   // Accept only occurs in IDLE, so DONE issue and a new accept are exclusive.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_out     <= '0;
         rem_out     <= '0;
         wdata_out   <= '0;
         out_valid   <= 1'b0;
         div_by_zero <= 1'b0;
      end else if (!stall) begin
         if (state == DONE) begin
            alu_out     <= quo_p1;
            rem_out     <= rem_p1;
            wdata_out   <= wdata_p1;
            out_valid   <= 1'b1;
            div_by_zero <= 1'b0;
         end else if (accept && !is_div) begin
            alu_out     <= alu_res;
            rem_out     <= '0;
            wdata_out   <= wdata_in;
            out_valid   <= 1'b1;
            div_by_zero <= 1'b0;
         end else if (accept && b == '0) begin
            alu_out     <= '1;
            rem_out     <= a;
            wdata_out   <= wdata_in;
            out_valid   <= 1'b1;
            div_by_zero <= 1'b1;
         end else begin
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_exec_unit_p.sv
// Scoreboard bench for exec_unit_p (WIDTH=16, NUM_FWD=3).
module tb_exec_unit_p;
   localparam int W  = 16;
   localparam int NF = 3;
   localparam int SW = 2;

   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                          XOR_ = 3'b100, SLL = 3'b101, SRL = 3'b110, DIV = 3'b111;

   logic          clk = 1'b0, rst = 1'b1, stall = 1'b0, in_valid = 1'b0;
   logic          in_ready, out_valid, div_busy, div_by_zero;
   logic [2:0]    op = '0;
   logic [W-1:0]  rs_data = '0, rt_data = '0, wdata_in = '0;
   logic          fwd_rs_en = 1'b0, fwd_rt_en = 1'b0;
   logic [SW-1:0] fwd_rs_sel = '0, fwd_rt_sel = '0;
   logic [W-1:0]  fwd_mem [NF];
   logic [NF*W-1:0] fwd_data;
   logic [W-1:0]  alu_out, rem_out, wdata_out;

   typedef struct packed {
      logic [W-1:0] alu;
      logic [W-1:0] rem;
      logic [W-1:0] wd;
      logic         dbz;
   } exp_t;

   exp_t sbq[$];
   int   tests = 0;
   int   fails = 0;
   logic stall_edge = 1'b0;

   assign fwd_data = {fwd_mem[2], fwd_mem[1], fwd_mem[0]};

   exec_unit_p #(.WIDTH(W), .NUM_FWD(NF)) dut (
      .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .rs_data(rs_data), .rt_data(rt_data),
      .fwd_rs_en(fwd_rs_en), .fwd_rt_en(fwd_rt_en),
      .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .fwd_data(fwd_data),
      .wdata_in(wdata_in), .out_valid(out_valid), .alu_out(alu_out),
      .rem_out(rem_out), .wdata_out(wdata_out), .div_busy(div_busy),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [W-1:0] eff(input logic en, input logic [SW-1:0] sel,
                                        input logic [W-1:0] d);
      if (en && int'(sel) < NF) return fwd_mem[sel];
      return d;
   endfunction

   function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic [W-1:0] w);
      exp_t e;
      e.alu = '0; e.rem = '0; e.wd = w; e.dbz = 1'b0;
      case (o)
         ADD:  e.alu = a + b;
         SUB:  e.alu = a - b;
         AND_: e.alu = a & b;
         OR_:  e.alu = a | b;
         XOR_: e.alu = a ^ b;
         SLL:  e.alu = a << b[3:0];
         SRL:  e.alu = a >> b[3:0];
         default: begin
            if (b == '0) begin
               e.alu = '1; e.rem = a; e.dbz = 1'b1;
            end else begin
               e.alu = a / b; e.rem = a % b;
            end
         end
      endcase
      return e;
   endfunction

   // Present one operation, expect acceptance on the next edge, queue its result.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] rs, input logic [W-1:0] rt,
                        input logic [W-1:0] w,
                        input logic rse = 1'b0, input logic [SW-1:0] rss = '0,
                        input logic rte = 1'b0, input logic [SW-1:0] rts = '0);
      op = o; rs_data = rs; rt_data = rt; wdata_in = w;
      fwd_rs_en = rse; fwd_rs_sel = rss; fwd_rt_en = rte; fwd_rt_sel = rts;
      in_valid = 1'b1;
      #1;
      check("in_ready_at_issue", W'(in_ready), W'(1'b1));
      sbq.push_back(model(o, eff(rse, rss, rs), eff(rte, rts, rt), w));
      @(posedge clk);
      #1;
      in_valid = 1'b0; fwd_rs_en = 1'b0; fwd_rt_en = 1'b0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(posedge clk) stall_edge <= stall;

   // A new result is one that appeared on an edge where stall was low.
   always @(negedge clk) begin
      if (out_valid && !stall_edge) begin
         exp_t e;
         if (sbq.size() == 0) begin
            check("unexpected_valid", W'(out_valid), W'(1'b0));
         end else begin
            e = sbq.pop_front();
            check("alu_out", alu_out, e.alu);
            check("rem_out", rem_out, e.rem);
            check("wdata_out", wdata_out, e.wd);
            check("div_by_zero", W'(div_by_zero), W'(e.dbz));
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      fwd_mem[0] = 16'h1111;
      fwd_mem[1] = 16'h0203;
      fwd_mem[2] = 16'h00F0;

      // reset state
      cyc(2);
      @(negedge clk);
      check("rst_alu", alu_out, W'(0));
      check("rst_rem", rem_out, W'(0));
      check("rst_wdata", wdata_out, W'(0));
      check("rst_valid", W'(out_valid), W'(1'b0));
      check("rst_dbz", W'(div_by_zero), W'(1'b0));
      check("rst_busy", W'(div_busy), W'(1'b0));
      check("rst_in_ready", W'(in_ready), W'(1'b0));
      rst = 1'b0;

      // first accept right after reset release, then idle clears out_valid
      issue(ADD, 16'hFFFF, 16'h0002, 16'hAAAA);
      cyc(1);
      @(negedge clk);
      check("idle_valid", W'(out_valid), W'(1'b0));

      // back-to-back ALU operations
      issue(SUB,  16'h0003, 16'h0005, 16'h0001);
      issue(AND_, 16'hF0F0, 16'hFF00, 16'h0002);
      issue(OR_,  16'h0F00, 16'h00F0, 16'h0003);
      issue(XOR_, 16'hFFFF, 16'h1234, 16'h0004);
      issue(SLL,  16'h0001, 16'h0013, 16'h0005);
      issue(SRL,  16'h8000, 16'h000F, 16'h0006);

      // forwarding, including an out-of-range select
      issue(OR_, 16'h1200, 16'h000F, 16'h0007, 1'b1, 2'd2);
      issue(OR_, 16'h1200, 16'h000F, 16'h0008, 1'b1, 2'd3);
      issue(ADD, 16'h0005, 16'h9999, 16'h0009, 1'b0, 2'd0, 1'b1, 2'd1);
      cyc(1);

      // 100 / 7 with operand churn and in_valid held while busy
      issue(DIV, 16'd100, 16'd7, 16'h5A5A);
      check("div_busy_t0", W'(div_busy), W'(1'b1));
      rs_data = 16'hFFFF; rt_data = '0; op = ADD; fwd_rs_en = 1'b1; in_valid = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk);
         @(negedge clk);
         check("div_busy_run", W'(div_busy), W'(1'b1));
         check("in_ready_run", W'(in_ready), W'(1'b0));
         check("valid_run", W'(out_valid), W'(1'b0));
         if (k == 16) begin
            in_valid = 1'b0; fwd_rs_en = 1'b0;
         end
      end
      @(posedge clk);
      @(negedge clk);
      check("div_latency_valid", W'(out_valid), W'(1'b1));
      check("div_done_busy", W'(div_busy), W'(1'b0));
      check("div_done_ready", W'(in_ready), W'(1'b1));
      #1;

      // divide by zero
      issue(DIV, 16'h1234, 16'h0000, 16'h0F0F);
      @(negedge clk);
      check("dbz_busy", W'(div_busy), W'(1'b0));
      cyc(1);
      @(negedge clk);
      check("dbz_clear", W'(div_by_zero), W'(1'b0));
      check("dbz_valid_clear", W'(out_valid), W'(1'b0));
      check("dbz_alu_hold", alu_out, 16'hFFFF);

      // stall during RUN does not delay completion
      issue(DIV, 16'd1000, 16'd3, 16'h0101);
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk);
         #1;
         stall = (k >= 2 && k <= 8);
      end
      @(posedge clk);
      @(negedge clk);
      check("stall_run_valid", W'(out_valid), W'(1'b1));
      #1;

      // stall held in DONE for three cycles
      issue(DIV, 16'hABCD, 16'h0013, 16'h7E7E);
      repeat (15) @(posedge clk);
      #1;
      stall = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         @(negedge clk);
         check("done_stall_valid", W'(out_valid), W'(1'b0));
         check("done_stall_alu", alu_out, 16'd333);
         check("done_stall_rem", rem_out, 16'd1);
         check("done_stall_busy", W'(div_busy), W'(1'b1));
      end
      stall = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("done_release_valid", W'(out_valid), W'(1'b1));
      #1;

      // reset in the middle of a division
      issue(DIV, 16'h7777, 16'h0005, 16'h3C3C);
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      sbq.delete();
      @(posedge clk);
      @(negedge clk);
      check("abort_alu", alu_out, W'(0));
      check("abort_rem", rem_out, W'(0));
      check("abort_wdata", wdata_out, W'(0));
      check("abort_valid", W'(out_valid), W'(1'b0));
      check("abort_busy", W'(div_busy), W'(1'b0));
      rst = 1'b0;
      #1;
      check("abort_in_ready", W'(in_ready), W'(1'b1));
      cyc(20);
      @(negedge clk);
      check("abort_no_result", W'(out_valid), W'(1'b0));
      check("abort_idle_busy", W'(div_busy), W'(1'b0));
      issue(ADD, 16'h0001, 16'h0001, 16'h00AA);
      cyc(2);

      check("scoreboard_empty", W'(sbq.size()), W'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/exec_unit_p.md
EXEC_UNIT_P -- requirements
Module: exec_unit_p

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits (legal 8..64).
REQ-002 Parameter NUM_FWD, default 4, number of forwarding sources (legal 2..8); SEL_W = clog2(NUM_FWD).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  downstream stall; output registers hold while high.
REQ-006 in_valid  in  1  operation presented this cycle.
REQ-007 in_ready  out  1  unit accepts an operation this cycle.
REQ-008 op  in  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 srl, 111 unsigned div.
REQ-009 rs_data, rt_data  in  WIDTH each  register-file operands A and B.
REQ-010 fwd_rs_en, fwd_rt_en  in  1 each  replace A / B with a forwarded value.
REQ-011 fwd_rs_sel, fwd_rt_sel  in  SEL_W each  forwarding source index.
REQ-012 fwd_data  in  NUM_FWD*WIDTH  source k at bits [k*WIDTH +: WIDTH].
REQ-013 wdata_in  in  WIDTH  store data, passed through alongside the result.
REQ-014 out_valid  out  1  result registers hold a new result.
REQ-015 alu_out, rem_out, wdata_out  out  WIDTH each  result or quotient, remainder, store data.
REQ-016 div_busy  out  1  divider iterating.
REQ-017 div_by_zero  out  1  qualifies out_valid: current result is a divide with B = 0.

Function
REQ-018 A = fwd_rs_en ? fwd_data[fwd_rs_sel] : rs_data; B likewise with the rt signals. A select index >= NUM_FWD yields the unforwarded operand.
REQ-019 in_ready = !stall && !div_busy (combinational); accept = in_valid && in_ready.
REQ-020 add/sub/logic results are modulo 2^WIDTH; carry and borrow discarded.
REQ-021 sll/srl shift A by B[clog2(WIDTH)-1:0], zero fill; upper bits of B ignored.
REQ-022 Non-div accept: alu_out = result, rem_out = 0, wdata_out = wdata_in, out_valid = 1, div_by_zero = 0 on the next edge (latency 1).
REQ-023 Divider FSM states: IDLE, RUN, DONE. Div accept with B != 0 moves IDLE->RUN and latches A, B, wdata_in.
REQ-024 RUN performs exactly WIDTH restoring-division iterations, one per cycle, then enters DONE; div_busy = 1 in RUN and DONE.
REQ-025 DONE with stall low writes quotient to alu_out, remainder to rem_out, latched wdata to wdata_out, sets out_valid = 1, and returns to IDLE. Accept-to-out_valid latency is WIDTH+1 cycles.
REQ-026 DONE with stall high holds in DONE until the first cycle stall is low.
REQ-027 Div accept with B = 0 skips RUN: next edge sets alu_out = all ones, rem_out = A, out_valid = 1, div_by_zero = 1.
REQ-028 Operand, forwarding and op changes during RUN/DONE have no effect on the division in flight.
REQ-029 Stall high: alu_out, rem_out, wdata_out, out_valid and div_by_zero hold; a RUN in progress keeps iterating.
REQ-030 Stall low with no accept and no DONE completion: out_valid and div_by_zero clear to 0; data outputs hold.
REQ-031 No operation is accepted while div_busy = 1 (at most one division in flight).

Reset
REQ-032 rst high on an edge forces FSM to IDLE and clears all output registers, out_valid, div_by_zero and the iteration counter to 0; div_busy and in_ready are 0 while rst is high.
REQ-033 rst takes priority over stall and accept and aborts any RUN/DONE division; no result from the aborted division is ever issued.
REQ-034 First accept is possible on the first edge after rst falls.

Verification
REQ-035 WIDTH=16: add A=0xFFFF, B=0x0002 -> next cycle alu_out=0x0001, out_valid=1; following idle cycle -> out_valid=0.
REQ-036 fwd_rs_en=1, fwd_rs_sel=2, fwd_data[2]=0x00F0, rt_data=0x000F, op=or -> alu_out=0x00FF; fwd_rs_sel=3 with NUM_FWD=3 -> rs_data used.
REQ-037 Div 100/7 accepted at cycle t -> div_busy=1 and in_ready=0 over t+1..t+16; at t+17 alu_out=14, rem_out=2, out_valid=1, div_busy=0.
REQ-038 Div 0x1234/0 -> next cycle alu_out=0xFFFF, rem_out=0x1234, div_by_zero=1, out_valid=1.
REQ-039 Stall held high from the DONE cycle for 3 cycles -> outputs unchanged and out_valid=0 throughout; result issues on the first cycle stall is low.
REQ-040 rst pulsed at iteration 8 of a division -> all outputs 0, in_ready=1 on the next cycle, aborted result never appears.
